cmd_saver: RTL and testbench
============================

// Module: cmd_saver
// PURPOSE
//  Encodes a RAM region as a TRS-80 /CMD byte stream; the inverse of the /CMD loader.
//  Reads guest RAM through a 1-cycle-latency read port. Emits loader-compatible
//  records over a valid/ready byte stream, feeding the HPS upload path (save to SD).
//  Any stream it emits must load back through the /CMD loader byte-for-byte.
// PARAMETERS
//  DATA  8   data bus width (record format fixes this at 8)
//  ADDR  16  address bus width
// PORTS
//  clock        in   1     system clock; single clock domain
//  reset_n      in   1     synchronous reset, active-low
//  start        in   1     1-cycle pulse: begin encoding; ignored while busy=1
//  start_addr   in   ADDR  first byte of region (inclusive)
//  end_addr     in   ADDR  last byte of region (inclusive)
//  exec_addr    in   ADDR  transfer (entry) address
//  exec_enable  in   1     1: end with type-2 transfer record; 0: end with a 0x00 byte
//  mem_rd       out  1     read strobe; mem_data is valid on the following cycle
//  mem_addr     out  ADDR  read address
//  mem_data     in   DATA  read data
//  out_data     out  DATA  stream byte
//  out_valid    out  1     out_data is valid
//  out_ready    in   1     sink accepts the byte when out_valid & out_ready
//  busy         out  1     encoding in progress
//  done         out  1     1-cycle pulse after the final byte is accepted
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): all outputs are 0; state=IDLE; remaining count=0.
//   Applies mid-stream too; no partial record is completed.
//  start latches start_addr, end_addr, exec_addr and exec_enable, and sets busy=1 on the next edge.
//   remaining = end_addr-start_addr+1, computed in ADDR+1 bits (full space = 2^ADDR).
//   If start_addr>end_addr: remaining=0, and only the terminator is emitted.
//  Chunking, n = bytes in next data record:
//   remaining>=256 -> n=256; remaining==255 -> n=254; otherwise n=remaining.
//   The loader cannot encode n=255, and n=0 is never emitted.
//  Data record: 0x01, LEN=(n+2) mod 256, addr[7:0], addr[15:8], then n data bytes.
//   The record address advances by n for each record.
//  Terminator: exec_enable=1 -> 0x02, 0x02, exec[7:0], exec[15:8]; exec_enable=0 -> single 0x00.
//  Handshake:
//   out_data must be stable while out_valid & !out_ready.
//   out_valid never drops without acceptance.
//   A byte is consumed only on an edge where valid & ready are both high.
//  FSM: IDLE -> REC_TYPE -> REC_LEN -> REC_LSB -> REC_MSB -> RD_REQ -> RD_WAIT -> DATA.
//   Each emit state holds until the byte is accepted.
//   RD_REQ: mem_rd=1 for exactly one cycle, mem_addr=current address.
//   RD_WAIT: registers mem_data into out_data.
//   DATA (on accept): next byte of the record -> RD_REQ; record finished with remaining>0 -> REC_TYPE;
//    record finished with remaining=0 -> TRM_TYPE (or EOF if exec_enable=0).
//   remaining=0 at start -> TRM_TYPE/EOF directly.
//   TRM_TYPE -> TRM_LEN -> TRM_LSB -> TRM_MSB -> FIN; EOF -> FIN.
//   FIN: done=1 and busy=0 for one cycle, then IDLE.
//  Exactly one mem_rd per data byte; no speculative reads.
//  Throughput: header bytes 1 per cycle; data bytes 1 per 3 cycles when out_ready=1.
//  start arriving in FIN or while busy: ignored.
//  Address wrap: the current address increments modulo 2^ADDR.
// STRUCTURE
//  Package cmd_pkg, shared with the loader:
//   CMD_TYPE_DATA=8'h01, CMD_TYPE_EXEC=8'h02, CMD_TYPE_EOF=8'h00
//   state enum type
//   function cmd_chunk_len(remaining) returning n
//   function cmd_len_byte(n) returning (n+2) mod 256
//  Single module; no sub-module. A registered output stage drives out_data/out_valid.
// TESTING
//  1. start=0x5200, end=0x5203, exec_enable=0, RAM=D0..D3
//     -> 01 06 00 52 D0 D1 D2 D3 00, then one done pulse.
//  2. Region 0x6000..0x60FF, exec 0x6000
//     -> 01 02 00 60 + 256 bytes, then 02 02 00 60; mem_rd count=256.
//  3. Region 0x7000..0x70FE (255 bytes), exec_enable=0
//     -> 01 00 00 70 + 254 bytes; 01 03 FE 70 + 1 byte; 00.
//  4. Case 1 with random out_ready (~50% low)
//     -> identical byte sequence; out_data stable while stalled; 4 reads.
//  5. start_addr>end_addr, exec 0x4000
//     -> only 02 02 00 40, then done; no mem_rd.
//  6. reset_n=0 during DATA
//     -> next cycle out_valid=busy=mem_rd=0; a new start yields the complete case-1 stream.
//  Loopback check: pipe the output into the /CMD loader; RAM image and execute_addr must match.

Source files
------------

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - /CMD record constants, FSM states and chunking helpers
package cmd_pkg;

  localparam int CMD_ADDR_W = 16;

  localparam logic [7:0] CMD_TYPE_DATA = 8'h01;
  localparam logic [7:0] CMD_TYPE_EXEC = 8'h02;
  localparam logic [7:0] CMD_TYPE_EOF  = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REC_TYPE,
    ST_REC_LEN,
    ST_REC_LSB,
    ST_REC_MSB,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_DATA,
    ST_TRM_TYPE,
    ST_TRM_LEN,
    ST_TRM_LSB,
    ST_TRM_MSB,
    ST_EOF,
    ST_FIN
  } cmd_state_e;

  // A length byte of 1 would mean n=255, which the loader cannot express.
  function automatic logic [8:0] cmd_chunk_len(input logic [CMD_ADDR_W:0] remaining);
    if (remaining >= (CMD_ADDR_W+1)'(256)) return 9'd256;
    else if (remaining == (CMD_ADDR_W+1)'(255)) return 9'd254;
    else return remaining[8:0];
  endfunction

  function automatic logic [7:0] cmd_len_byte(input logic [8:0] n);
    return n[7:0] + 8'd2;
  endfunction

endpackage

// File: rtl/cmd_saver.sv
// rtl/cmd_saver.sv - encodes a RAM region as a TRS-80 /CMD byte stream
import cmd_pkg::*;

module cmd_saver #(
  parameter int DATA = 8,
  parameter int ADDR = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [ADDR-1:0] start_addr,
  input  logic [ADDR-1:0] end_addr,
  input  logic [ADDR-1:0] exec_addr,
  input  logic            exec_enable,
  output logic            mem_rd,
  output logic [ADDR-1:0] mem_addr,
  input  logic [DATA-1:0] mem_data,
  output logic [DATA-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  cmd_state_e      state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] exec_q, exec_d;
  logic            exec_en_q, exec_en_d;
  logic [ADDR:0]   rem_q, rem_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [DATA-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            acc;

  assign acc       = out_valid_q & out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign mem_rd    = (state_q == ST_RD_REQ);
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done      = (state_q == ST_FIN);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    exec_d      = exec_q;
    exec_en_d   = exec_en_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    // Each transition into an emit state preloads that state's byte into the output register.
    case (state_q)
      ST_IDLE: if (start) begin
        addr_d      = start_addr;
        exec_d      = exec_addr;
        exec_en_d   = exec_enable;
        rem_d       = (end_addr >= start_addr) ? ({1'b0, end_addr} - {1'b0, start_addr} + 1'b1) : '0;
        out_valid_d = 1'b1;
        if (end_addr >= start_addr) begin
          state_d = ST_REC_TYPE; out_data_d = CMD_TYPE_DATA;
        end else if (exec_enable) begin
          state_d = ST_TRM_TYPE; out_data_d = CMD_TYPE_EXEC;
        end else begin
          state_d = ST_EOF;      out_data_d = CMD_TYPE_EOF;
        end
      end
      ST_REC_TYPE: if (acc) begin
        cnt_d      = cmd_chunk_len(rem_q);
        out_data_d = cmd_len_byte(cmd_chunk_len(rem_q));
        state_d    = ST_REC_LEN;
      end
      ST_REC_LEN: if (acc) begin out_data_d = addr_q[7:0];  state_d = ST_REC_LSB; end
      ST_REC_LSB: if (acc) begin out_data_d = addr_q[15:8]; state_d = ST_REC_MSB; end
      ST_REC_MSB: if (acc) begin out_valid_d = 1'b0;        state_d = ST_RD_REQ;  end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        out_data_d  = mem_data;
        out_valid_d = 1'b1;
        state_d     = ST_DATA;
      end
      ST_DATA: if (acc) begin
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q != 9'd1) begin
          out_valid_d = 1'b0; state_d = ST_RD_REQ;
        end else if (rem_q != (ADDR+1)'(1)) begin
          out_data_d = CMD_TYPE_DATA; state_d = ST_REC_TYPE;
        end else if (exec_en_q) begin
          out_data_d = CMD_TYPE_EXEC; state_d = ST_TRM_TYPE;
        end else begin
          out_data_d = CMD_TYPE_EOF;  state_d = ST_EOF;
        end
      end
      ST_TRM_TYPE: if (acc) begin out_data_d = 8'h02;        state_d = ST_TRM_LEN; end
      ST_TRM_LEN:  if (acc) begin out_data_d = exec_q[7:0];  state_d = ST_TRM_LSB; end
      ST_TRM_LSB:  if (acc) begin out_data_d = exec_q[15:8]; state_d = ST_TRM_MSB; end
      ST_TRM_MSB, ST_EOF: if (acc) begin out_valid_d = 1'b0; state_d = ST_FIN; end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      exec_q      <= '0;
      exec_en_q   <= 1'b0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      exec_q      <= exec_d;
      exec_en_q   <= exec_en_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cmd_saver.sv
// tb/tb_cmd_saver.sv - randomized self-checking bench for cmd_saver against a /CMD stream model
module tb_cmd_saver;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0, end_addr = '0, exec_addr = '0;
  logic        exec_enable = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, done;

  cmd_saver dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
    .exec_enable(exec_enable), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [65536];
  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  int  vectors = 0, miscompares = 0;
  int  rd_cnt, done_cnt, stall_err, exp_reads;
  bit  collect = 0, rand_ready = 0;
  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;

  always @(posedge clock) if (mem_rd) mem_data <= ram[mem_addr];

  always @(posedge clock) begin
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clock) begin
    if (collect) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (mem_rd) rd_cnt++;
      if (done) done_cnt++;
      if (pv && !pr && (!out_valid || out_data !== pd)) stall_err++;
    end
    pv = out_valid; pr = out_ready; pd = out_data;
  end

  // Expected stream straight from the record rules: 256-byte chunks, never 255.
  task automatic build_exp(input int s, input int e, input int x, input bit en);
    int rem, a, n;
    exp_q.delete();
    exp_reads = 0;
    rem = (e >= s) ? e - s + 1 : 0;
    a = s;
    while (rem > 0) begin
      n = (rem >= 256) ? 256 : (rem == 255) ? 254 : rem;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'((n + 2) % 256));
      exp_q.push_back(8'(a % 256));
      exp_q.push_back(8'((a / 256) % 256));
      for (int i = 0; i < n; i++) exp_q.push_back(ram[(a + i) % 65536]);
      exp_reads += n;
      a = (a + n) % 65536;
      rem -= n;
    end
    if (en) begin
      exp_q.push_back(8'h02); exp_q.push_back(8'h02);
      exp_q.push_back(8'(x % 256)); exp_q.push_back(8'((x / 256) % 256));
    end else begin
      exp_q.push_back(8'h00);
    end
  endtask

  function automatic bit streams_equal();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  task automatic run_stream(input int s, input int e, input int x, input bit en,
                            input bit rnd, input bit extra, output bit to);
    int budget;
    budget = 40 * (((e >= s) ? e - s + 1 : 0) + 20);
    got_q.delete();
    rd_cnt = 0; done_cnt = 0; stall_err = 0;
    rand_ready = rnd;
    collect = 1;
    @(negedge clock);
    start_addr = 16'(s); end_addr = 16'(e); exec_addr = 16'(x); exec_enable = en; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    to = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin to = 0; break; end
      if (extra && c == 3) begin
        start_addr = 16'h1234; end_addr = 16'h1300; exec_enable = ~en; start = 1'b1;
      end
    end
    if (extra) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    repeat (3) @(negedge clock);
    collect = 0;
    rand_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if ({out_valid, busy, done, mem_rd, out_data, mem_addr} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got v=%0b b=%0b d=%0b rd=%0b data=%h addr=%h required all 0",
               out_valid, busy, done, mem_rd, out_data, mem_addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_scenario(input string name, input int s, input int e, input int x,
                               input bit en, input bit rnd, input bit extra);
    bit to;
    build_exp(s, e, x, en);
    run_stream(s, e, x, en, rnd, extra, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL %s_timeout got no done required done", name);
    end
    vectors++;
    if (!streams_equal()) begin
      miscompares++;
      $display("FAIL %s_stream got %0d bytes (first %h) required %0d bytes (first %h)",
               name, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q.size(), exp_q[0]);
    end
    vectors++;
    if (rd_cnt !== exp_reads) begin
      miscompares++;
      $display("FAIL %s_reads got %0d required %0d", name, rd_cnt, exp_reads);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_done_pulses got %0d required 1", name, done_cnt);
    end
    vectors++;
    if (stall_err !== 0) begin
      miscompares++;
      $display("FAIL %s_stall_stability got %0d violations required 0", name, stall_err);
    end
  endtask

  task automatic test_mid_reset();
    int c;
    got_q.delete();
    collect = 1;
    @(negedge clock);
    start_addr = 16'h5200; end_addr = 16'h5203; exec_enable = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    c = 0;
    while (got_q.size() < 5 && c < 200) begin @(negedge clock); c++; end
    collect = 0;
    vectors++;
    if (c >= 200) begin
      miscompares++;
      $display("FAIL mid_reset_reach_data got %0d bytes required 5", got_q.size());
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if ({out_valid, busy, mem_rd} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got v=%0b b=%0b rd=%0b required 000", out_valid, busy, mem_rd);
    end
    @(negedge clock);
    reset_n = 1'b1;
    test_scenario("after_reset", 32'h5200, 32'h5203, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_scenario("start_ignored", 32'h5200, 32'h5203, 32'h5200, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_fin got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_random();
    int s, len, e;
    for (int k = 0; k < 4; k++) begin
      s   = $urandom_range(0, 16'hFFFF);
      len = $urandom_range(1, 600);
      e   = (s + len - 1 > 16'hFFFF) ? 16'hFFFF : s + len - 1;
      test_scenario($sformatf("random%0d", k), s, e, $urandom_range(0, 16'hFFFF),
                    1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h5200] = 8'hD0; ram[16'h5201] = 8'hD1; ram[16'h5202] = 8'hD2; ram[16'h5203] = 8'hD3;
    test_reset();
    test_scenario("small", 32'h5200, 32'h5203, 0, 1'b0, 1'b0, 1'b0);
    test_scenario("full_chunk", 32'h6000, 32'h60FF, 32'h6000, 1'b1, 1'b0, 1'b0);
    test_scenario("len255", 32'h7000, 32'h70FE, 0, 1'b0, 1'b0, 1'b0);
    test_scenario("stall", 32'h5200, 32'h5203, 0, 1'b0, 1'b1, 1'b0);
    test_scenario("reversed", 32'h5000, 32'h4FFF, 32'h4000, 1'b1, 1'b0, 1'b0);
    test_scenario("single_byte", 32'hFFFF, 32'hFFFF, 32'h1234, 1'b1, 1'b1, 1'b0);
    test_scenario("two_chunks", 32'h8000, 32'h8200, 32'h8000, 1'b1, 1'b1, 1'b0);
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
